// File: rtl/seq_pkg.sv
// Shared types and constants for the serial receive path.
// Holds the deframer state encoding, the byte type and default framing constants.
// No logic; imported by every receive-side block.
package seq_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  localparam byte_t SYNC_BYTE_DEF = 8'hA5;
  localparam int    FRAME_LEN_DEF = 4;

endpackage

// File: rtl/seq_shift_window.sv
// LSB-first 8-bit shift window with a saturating fill counter (0..8).
// Window and fill are registered; next-window and "fill reaches 8" are
// exposed combinationally so the caller can match on the bit being sampled.
module seq_shift_window
  import seq_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,   // clears the fill count only; window contents kept
  input  logic  shift_i,   // accepted bit this cycle
  input  logic  bit_i,
  output byte_t win_d_o,   // window including the bit being sampled
  output byte_t win_q_o,   // registered window
  output logic  full_d_o   // fill count is 8 including the bit being sampled
);

  byte_t      win_q, win_d;
  logic [3:0] fill_q, fill_d;

  // Next window and fill: newest bit enters at bit 7, so the oldest of the
  // last eight bits lands in bit 0 (arrival order == bit order).
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = 4'd0;
    end else if (shift_i) begin
      win_d = {bit_i, win_q[7:1]};
      if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
    end
  end

  // Window and fill registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  assign win_d_o  = win_d;
  assign win_q_o  = win_q;
  assign full_d_o = (fill_d == 4'd8);

endmodule

// File: rtl/seq_deframer.sv
// Serial-to-byte deframer: hunts a sync byte at any bit offset, then emits
// FRAME_LEN payload bytes per frame and verifies the sync byte between frames.
// Outputs registered; byte strobe one clock after the 8th bit; no backpressure.
module seq_deframer
  import seq_pkg::*;
#(
  parameter byte_t SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int    FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       bit_en_i,
  input  logic       bit_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       sof_o,
  output logic       locked_o,
  output logic       sync_err_o
);

  localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       sof_arm_q, sof_arm_d;
  byte_t      data_q, data_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       err_q, err_d;
  logic       locked_q;

  logic       accept;
  byte_t      win_d;
  byte_t      win_q_unused;
  logic       full_d;

  assign accept = enable_i & bit_en_i;

  seq_shift_window u_window (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (~enable_i),
    .shift_i  (accept),
    .bit_i    (bit_i),
    .win_d_o  (win_d),
    .win_q_o  (win_q_unused),
    .full_d_o (full_d)
  );

  // Next-state, counters and strobes; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sof_arm_d  = sof_arm_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    err_d      = 1'b0;

    if (!enable_i) begin
      // Abandon any partial byte silently.
      state_d    = HUNT;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sof_arm_d  = 1'b0;
    end else if (bit_en_i) begin
      unique case (state_q)
        HUNT: begin
          if (full_d && (win_d == SYNC_BYTE)) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sof_arm_d  = 1'b1;
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d     = win_d;
            valid_d    = 1'b1;
            sof_d      = sof_arm_q;
            sof_arm_d  = 1'b0;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == FRAME_LEN_B) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            if (win_d == SYNC_BYTE) begin
              state_d   = PAYLOAD;
              sof_arm_d = 1'b1;
            end else begin
              // Fill is already saturated at 8 here, so HUNT can realign
              // on the very next bit (one-bit slip).
              state_d = HUNT;
              err_d   = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sof_arm_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sof_arm_q  <= sof_arm_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      err_q      <= err_d;
      locked_q   <= (state_d != HUNT);
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign sof_o      = sof_q;
  assign locked_o   = locked_q;
  assign sync_err_o = err_q;

endmodule

// File: tb/tb_seq_deframer.sv
// Self-checking bench for seq_deframer: directed bit streams, scoreboard of
// expected payload bytes checked by an independent output monitor.
// Second instance with an all-zero sync byte checks the fill-count guard.
module tb_seq_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0;
  logic       en_z = 1'b0;
  logic       bit_en = 1'b0;
  logic       bit_s = 1'b0;
  logic       sel_z = 1'b0;

  logic [7:0] data_a, data_z;
  logic       valid_a, sof_a, locked_a, err_a;
  logic       valid_z, sof_z, locked_z, err_z;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  time t_prev = 0;
  time t_last = 0;

  logic [8:0] exp_q[$];   // {sof, data}

  always #5 clk = ~clk;

  seq_deframer #(.SYNC_BYTE(8'hA5), .FRAME_LEN(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (en_a),
    .bit_en_i   (bit_en & ~sel_z),
    .bit_i      (bit_s),
    .data_o     (data_a),
    .valid_o    (valid_a),
    .sof_o      (sof_a),
    .locked_o   (locked_a),
    .sync_err_o (err_a)
  );

  seq_deframer #(.SYNC_BYTE(8'h00), .FRAME_LEN(4)) dut_z (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (en_z),
    .bit_en_i   (bit_en & sel_z),
    .bit_i      (bit_s),
    .data_o     (data_z),
    .valid_o    (valid_z),
    .sof_o      (sof_z),
    .locked_o   (locked_z),
    .sync_err_o (err_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every byte strobe, counts sync errors.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) begin
        t_prev = t_last;
        t_last = $time;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", data_a);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("byte_data", {24'd0, data_a}, {24'd0, e[7:0]});
          chk("byte_sof", {31'd0, sof_a}, {31'd0, e[8]});
        end
      end
      if (err_a) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    bit_s  = b;
    tick();
    bit_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic sof);
    exp_q.push_back({sof, b});
  endtask

  task automatic drop_enable();
    en_a = 1'b0;
    tick();
    chk("drop_locked", {31'd0, locked_a}, 32'd0);
    chk("drop_no_err", {31'd0, err_a}, 32'd0);
    en_a = 1'b1;
  endtask

  initial begin
    logic [7:0] b;

    // Reset state
    #2;
    chk("rst_data", {24'd0, data_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_sof", {31'd0, sof_a}, 32'd0);
    chk("rst_locked", {31'd0, locked_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: aligned stream, two frames
    en_a = 1'b1;
    send_byte(8'hA5, 0);
    chk("t1_locked", {31'd0, locked_a}, 32'd1);
    expect_byte(8'h11, 1'b1); send_byte(8'h11, 0);
    expect_byte(8'h22, 1'b0); send_byte(8'h22, 0);
    expect_byte(8'h33, 1'b0); send_byte(8'h33, 0);
    expect_byte(8'h44, 1'b0); send_byte(8'h44, 0);
    send_byte(8'hA5, 0);
    chk("t1_check_locked", {31'd0, locked_a}, 32'd1);
    expect_byte(8'h55, 1'b1); send_byte(8'h55, 0);
    drop_enable();

    // 2: three junk bits, sync at offset 3
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_byte(8'hA5, 0);
    chk("t2_locked", {31'd0, locked_a}, 32'd1);
    expect_byte(8'h01, 1'b1); send_byte(8'h01, 0);
    expect_byte(8'h02, 1'b0); send_byte(8'h02, 0);
    expect_byte(8'h03, 1'b0); send_byte(8'h03, 0);
    expect_byte(8'h04, 1'b0); send_byte(8'h04, 0);
    chk("t2_no_err", err_seen, 32'd0);

    // 3: bad sync byte in CHECK
    send_byte(8'h5A, 0);
    chk("t3_err_pulse", {31'd0, err_a}, 32'd1);
    chk("t3_unlocked", {31'd0, locked_a}, 32'd0);
    tick();
    chk("t3_err_one_cycle", {31'd0, err_a}, 32'd0);
    chk("t3_err_count", err_seen, 32'd1);
    drop_enable();

    // 4: bit_en every other cycle
    send_byte(8'hA5, 1);
    expect_byte(8'h11, 1'b1); send_byte(8'h11, 1);
    expect_byte(8'h22, 1'b0); send_byte(8'h22, 1);
    expect_byte(8'h33, 1'b0); send_byte(8'h33, 1);
    expect_byte(8'h44, 1'b0); send_byte(8'h44, 1);
    tick();
    chk("t4_spacing", 32'(t_last - t_prev), 32'd160);
    drop_enable();
    chk("t4_err_count", err_seen, 32'd1);

    // 5: enable dropped mid-byte, relock on fresh sync
    send_byte(8'hA5, 0);
    expect_byte(8'h11, 1'b1); send_byte(8'h11, 0);
    b = 8'h22;
    for (int i = 0; i < 4; i++) send_bit(b[i], 0);
    drop_enable();
    b = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(b[i], 0);
    chk("t5_no_lock_7bits", {31'd0, locked_a}, 32'd0);
    send_bit(b[7], 0);
    chk("t5_relock", {31'd0, locked_a}, 32'd1);
    expect_byte(8'h01, 1'b1); send_byte(8'h01, 0);
    expect_byte(8'h02, 1'b0); send_byte(8'h02, 0);
    expect_byte(8'h03, 1'b0); send_byte(8'h03, 0);
    expect_byte(8'h04, 1'b0); send_byte(8'h04, 0);
    send_byte(8'hA5, 0);
    chk("t5_err_count", err_seen, 32'd1);

    // Reset mid-frame: asynchronous return to reset values
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", {24'd0, data_a}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked_a}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    tick();
    rst = 1'b0;
    en_a = 1'b0;
    tick();

    // 6: all-zero sync byte needs a full window
    sel_z = 1'b1;
    en_z  = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("t6_no_lock", {31'd0, locked_z}, 32'd0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 0);
    chk("t6_no_lock_7z", {31'd0, locked_z}, 32'd0);
    send_bit(1'b0, 0);
    chk("t6_lock", {31'd0, locked_z}, 32'd1);
    en_z = 1'b0;
    tick();
    chk("t6_quiet", {21'd0, valid_z, sof_z, err_z, data_z}, 32'd0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_deframer.md
# seq_deframer

Receive-side counterpart of the byte-to-bit serializer in the sequence-detector path. It consumes a serial bit stream (LSB-first per byte, one bit per qualified clock), hunts for a sync byte at any bit offset, then reassembles fixed-length frames of payload bytes. Each byte is presented on a parallel output with a one-cycle valid strobe. Lock status and sync errors are reported for the downstream control FSM.

## Interface
- SYNC_BYTE, 8'hA5: frame sync pattern, compared in arrival order (first bit received = bit 0).
- FRAME_LEN, 4: payload bytes per frame after each sync byte; legal range 1..255.
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- enable_i  input  1  synchronous run enable; low forces HUNT and clears all counters and the window-fill count.
- bit_en_i  input  1  qualifies bit_i for this cycle; ignored while enable_i low.
- bit_i  input  1  serial data bit.
- data_o  output  8  assembled payload byte, bit 0 = first received.
- valid_o  output  1  one-cycle strobe, data_o valid.
- sof_o  output  1  coincides with valid_o on the first payload byte of each frame.
- locked_o  output  1  high in PAYLOAD and CHECK states.
- sync_err_o  output  1  one-cycle pulse when the expected sync byte is missing.

## Operation
- States: HUNT, PAYLOAD, CHECK (enum in package).
- Shift window: on every accepted bit (enable_i & bit_en_i), window <= {bit_i, window[7:1]}. The match test uses this next-window value.
- Fill counter (0..8, saturating) counts accepted bits since entering HUNT from reset or from enable_i low. A sync match is accepted in HUNT only when the fill counter reaches 8 with this bit.
- HUNT: on match, go to PAYLOAD with bit_cnt=0 and byte_cnt=0, and arm sof.
- PAYLOAD: bit_cnt (3-bit) increments per accepted bit. When bit_cnt wraps 7->0:
  - data_o <= next-window, valid_o=1, sof_o=armed, disarm sof.
  - byte_cnt increments. When it reaches FRAME_LEN, go to CHECK with bit_cnt=0.
- CHECK: collect 8 bits.
  - If they equal SYNC_BYTE: go to PAYLOAD, byte_cnt=0, arm sof.
  - Otherwise: pulse sync_err_o and go to HUNT. The window is retained and the fill counter is set to 8, so the next bit can realign at a one-bit slip.
- CHECK bytes are never output on data_o.
- enable_i low in any state: HUNT next cycle, bit_cnt/byte_cnt/fill cleared, no partial byte emitted, no sync_err_o.
- Cycles with bit_en_i low change nothing. All strobes deassert.
- byte_cnt width is 8 bits.

## Timing
- Reset values: data_o=8'h00, valid_o=0, sof_o=0, locked_o=0, sync_err_o=0, state=HUNT, window=0, all counters 0.
- All outputs are registered.
- valid_o and sof_o assert the cycle after the edge that samples the 8th bit of a byte. Latency from the 8th bit_en_i cycle to valid_o is 1 clock.
- locked_o rises the cycle after the sync-completing bit is sampled. It falls the cycle after the failing CHECK bit or after enable_i is sampled low.
- sync_err_o is asserted in the same cycle that locked_o falls.
- Minimum spacing between valid_o pulses is 8 clocks (bit_en_i held high).
- Reset asserted mid-frame: immediate return to reset values. No output completes.

## Structure
- Package seq_pkg: state enum (HUNT, PAYLOAD, CHECK), default SYNC_BYTE constant, and the 8-bit byte type.
- One sub-module, seq_shift_window: 8-bit LSB-first shift register with saturating fill counter and a registered parallel output. It is shared with future receive blocks.
- FSM, byte counter and strobe generation stay in seq_deframer.

## Test plan
- Reset then enable_i=1; stream A5, 11, 22, 33, 44, A5, 55 (LSB-first, bit_en_i=1) -> valid_o pulses with data_o 11, 22, 33, 44, 55; sof_o on 11 and 55; locked_o high from the 8th bit of the first A5.
- Three junk bits then A5, 01, 02, 03, 04 -> lock at the offset-3 sync; bytes 01..04 output; no sync_err_o.
- Locked frame followed by 5A instead of A5 in CHECK -> one sync_err_o pulse, locked_o=0, no valid_o for 5A.
- Stream begins with A5 but bit_en_i toggles every other cycle -> same bytes as the first test; valid_o spacing is 16 clocks.
- enable_i dropped after 4 bits of payload byte 2, then re-raised with a fresh A5 and payload -> no partial byte, no sync_err_o; relock only after 8 new bits.
- SYNC_BYTE=8'h00: after reset, feed 7 zeros then 1 -> no lock; 8 zeros -> lock.
